// File: rtl/img_mode_ctrl.sv
`default_nettype none
// ============================================================================
// img_mode_ctrl : debounced key shadow config, committed at frame start
// Revision 1.0
// ============================================================================
module img_mode_ctrl #(
  parameter int unsigned DEBOUNCE_MAX = 999_999,
  parameter int unsigned THRESH_BASE  = 60,
  parameter int unsigned THRESH_STEP  = 10,
  parameter int unsigned THRESH_MIN   = 30,
  parameter int unsigned THRESH_MAX   = 90,
  parameter bit          PINJIE_DEF   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_img,
  input  logic       key_bri,
  input  logic       key_duibi,
  input  logic       key_th_up,
  input  logic       key_th_dn,
  input  logic       key_pinjie,
  input  logic       cam_vs,
  output logic [1:0] src_sel,
  output logic       pinjie_en,
  output logic [7:0] sobel_thresh,
  output logic       frame_mute,
  output logic       cfg_update,
  output logic       mode_pending
);

  localparam int CW = $clog2(DEBOUNCE_MAX + 2);

  logic [5:0] keys_n;
  logic [5:0] ev;
  assign keys_n = {key_pinjie, key_th_dn, key_th_up, key_duibi, key_bri, key_img};

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_deb
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst || keys_n[gi]) cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_MAX + 1)) cnt <= cnt + 1'b1;
    end
    assign ev[gi] = ~keys_n[gi] & (cnt == CW'(DEBOUNCE_MAX));
  end

  logic       sh_sobel, sh_color, sh_pinjie, vs_d;
  logic [7:0] sh_thresh;
  logic [1:0] sh_src;
  logic [8:0] th_up9;
  logic [7:0] th_up, th_dn;
  logic       fs, diff;

  assign sh_src = sh_sobel ? 2'd2 : {1'b0, sh_color};
  assign fs     = cam_vs & ~vs_d;
  assign diff   = (sh_src != src_sel) | (sh_pinjie != pinjie_en) | (sh_thresh != sobel_thresh);

  // 9-bit add and guarded subtract so saturation never sees a wrapped value
  assign th_up9 = {1'b0, sh_thresh} + 9'(THRESH_STEP);
  assign th_up  = (th_up9 > 9'(THRESH_MAX)) ? 8'(THRESH_MAX) : th_up9[7:0];
  assign th_dn  = ({1'b0, sh_thresh} < 9'(THRESH_MIN + THRESH_STEP)) ? 8'(THRESH_MIN)
                                                                    : sh_thresh - 8'(THRESH_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_sobel     <= 1'b0;
      sh_color     <= 1'b0;
      sh_pinjie    <= PINJIE_DEF;
      sh_thresh    <= 8'(THRESH_BASE);
      src_sel      <= 2'd0;
      pinjie_en    <= PINJIE_DEF;
      sobel_thresh <= 8'(THRESH_BASE);
      frame_mute   <= 1'b0;
      cfg_update   <= 1'b0;
      mode_pending <= 1'b0;
      vs_d         <= 1'b0;
    end else begin
      vs_d         <= cam_vs;
      mode_pending <= diff;
      // Commit uses the shadow as it stood before this cycle's key events
      if (fs && diff) begin
        src_sel      <= sh_src;
        pinjie_en    <= sh_pinjie;
        sobel_thresh <= sh_thresh;
        cfg_update   <= 1'b1;
        frame_mute   <= 1'b1;
      end else begin
        cfg_update <= 1'b0;
        if (fs) frame_mute <= 1'b0;
      end
      if (ev[0]) sh_sobel <= ~sh_sobel;
      if (ev[1]) sh_color <= 1'b0;
      else if (ev[2]) sh_color <= 1'b1;
      if (ev[3] && !ev[4]) sh_thresh <= th_up;
      else if (ev[4] && !ev[3]) sh_thresh <= th_dn;
      if (ev[5]) sh_pinjie <= ~sh_pinjie;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_mode_ctrl.sv
`default_nettype none
// ============================================================================
// tb_img_mode_ctrl : scenario tasks plus randomized run against a frame model
// Revision 1.0
// ============================================================================
module tb_img_mode_ctrl;

  localparam int D      = 3;
  localparam int FRAME  = 40;
  localparam int VS_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] keys = 6'h3F;   // {pinjie, dn, up, duibi, bri, img}
  logic       cam_vs = 1'b0;
  logic [1:0] src_sel;
  logic       pinjie_en, frame_mute, cfg_update, mode_pending;
  logic [7:0] sobel_thresh;

  img_mode_ctrl #(.DEBOUNCE_MAX(D)) dut (
    .clk(clk), .rst(rst),
    .key_img(keys[0]), .key_bri(keys[1]), .key_duibi(keys[2]),
    .key_th_up(keys[3]), .key_th_dn(keys[4]), .key_pinjie(keys[5]),
    .cam_vs(cam_vs), .src_sel(src_sel), .pinjie_en(pinjie_en),
    .sobel_thresh(sobel_thresh), .frame_mute(frame_mute),
    .cfg_update(cfg_update), .mode_pending(mode_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  // Reference model: runs of low samples, shadow and active configuration
  int run [6];
  bit m_sobel, m_color, m_pj, m_vsd, m_mute, m_upd, m_pend, a_pj;
  int m_th, a_src, a_th;

  function automatic int sh_src();
    return m_sobel ? 2 : int'(m_color);
  endfunction

  function automatic logic [13:0] exp_vec();
    return {2'(a_src), a_pj, 8'(a_th), m_mute, m_upd, m_pend};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {src_sel, pinjie_en, sobel_thresh, frame_mute, cfg_update, mode_pending};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) run[i] = 0;
    m_sobel = 0; m_color = 0; m_pj = 1; m_th = 60;
    a_src = 0; a_pj = 1; a_th = 60;
    m_vsd = 0; m_mute = 0; m_upd = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic [5:0] k, input logic vs);
    bit ev [6];
    bit fs, diff;
    for (int i = 0; i < 6; i++) begin
      run[i] = k[i] ? 0 : run[i] + 1;
      ev[i]  = (run[i] == D + 1);
    end
    fs   = vs && !m_vsd;
    diff = (sh_src() != a_src) || (m_pj != a_pj) || (m_th != a_th);
    m_pend = diff;
    if (fs && diff) begin
      a_src = sh_src(); a_pj = m_pj; a_th = m_th;
      m_upd = 1; m_mute = 1;
    end else begin
      m_upd = 0;
      if (fs) m_mute = 0;
    end
    if (ev[0]) m_sobel = !m_sobel;
    if (ev[1]) m_color = 0;
    else if (ev[2]) m_color = 1;
    if (ev[3] && !ev[4]) m_th = (m_th + 10 > 90) ? 90 : m_th + 10;
    else if (ev[4] && !ev[3]) m_th = (m_th - 10 < 30) ? 30 : m_th - 10;
    if (ev[5]) m_pj = !m_pj;
    m_vsd = vs;
  endtask

  // One clock: drive at negedge, model follows the edge, return at negedge
  task automatic tick(input logic [5:0] k);
    keys   = k;
    cam_vs = (phase < VS_LEN);
    @(posedge clk);
    model_step(k, cam_vs);
    phase = (phase + 1) % FRAME;
    @(negedge clk);
  endtask

  task automatic press(input logic [5:0] mask);
    repeat (D + 1) tick(~mask);
    tick(6'h3F);
  endtask

  task automatic idle_until(input int ph);
    while (phase != ph) tick(6'h3F);
  endtask

  task automatic do_reset();
    rst = 1'b1; keys = 6'h3F;
    cam_vs = (phase < VS_LEN);
    @(posedge clk);
    model_reset();
    phase = (phase + 1) % FRAME;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== {2'd0, 1'b1, 8'd60, 3'b000}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {2'd0, 1'b1, 8'd60, 3'b000});
    end
    repeat (2 * FRAME) begin
      tick(6'h3F);
      checks++;
      if (cfg_update !== 1'b0 || frame_mute !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_frames: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_img();
    int mutes, pulses;
    idle_until(10);
    press(6'h01);
    checks++;
    if (mode_pending !== 1'b1 || src_sel !== 2'd0) begin
      errors++; $display("FAIL img_pending: got pend=%b src=%0d expected pend=1 src=0", mode_pending, src_sel);
    end
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (src_sel !== 2'd2 || cfg_update !== 1'b1) begin
      errors++; $display("FAIL img_commit: got src=%0d upd=%b expected src=2 upd=1", src_sel, cfg_update);
    end
    mutes = int'(frame_mute); pulses = int'(cfg_update);
    repeat (FRAME - 1) begin
      tick(6'h3F);
      mutes += int'(frame_mute); pulses += int'(cfg_update);
    end
    tick(6'h3F);
    checks++;
    if (mutes != FRAME || pulses != 1 || frame_mute !== 1'b0) begin
      errors++; $display("FAIL img_mute: got mutes=%0d pulses=%0d end=%b expected %0d 1 0", mutes, pulses, frame_mute, FRAME);
    end
    idle_until(10);
    repeat (D) tick(6'h3E);
    repeat (3) tick(6'h3F);
    checks++;
    if (mode_pending !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL img_glitch: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_thresh();
    idle_until(VS_LEN);
    repeat (5) press(6'h08);
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (sobel_thresh !== 8'd90 || cfg_update !== 1'b1) begin
      errors++; $display("FAIL thresh_sat_max: got %0d upd=%b expected 90 upd=1", sobel_thresh, cfg_update);
    end
    idle_until(VS_LEN);
    repeat (7) press(6'h10);
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (sobel_thresh !== 8'd30 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL thresh_sat_min: got %0d expected 30", sobel_thresh);
    end
  endtask

  task automatic test_colour();
    idle_until(VS_LEN);
    press(6'h05);               // img off sobel, duibi -> contrast
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (src_sel !== 2'd1) begin
      errors++; $display("FAIL colour_contrast: got %0d expected 1", src_sel);
    end
    idle_until(VS_LEN);
    press(6'h06);               // bri and duibi together: bri wins
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (src_sel !== 2'd0 || cfg_update !== 1'b1) begin
      errors++; $display("FAIL colour_bri_wins: got src=%0d upd=%b expected 0 1", src_sel, cfg_update);
    end
    idle_until(VS_LEN);
    press(6'h18);               // up and dn together cancel
    checks++;
    if (mode_pending !== 1'b0) begin
      errors++; $display("FAIL th_cancel_pending: got %b expected 0", mode_pending);
    end
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (cfg_update !== 1'b0 || sobel_thresh !== 8'd30) begin
      errors++; $display("FAIL th_cancel_commit: got upd=%b th=%0d expected 0 30", cfg_update, sobel_thresh);
    end
  endtask

  task automatic test_pinjie();
    idle_until(FRAME - D);
    repeat (D + 1) tick(6'h1F);  // event lands on the fs tick
    checks++;
    if (cfg_update !== 1'b0 || pinjie_en !== 1'b1) begin
      errors++; $display("FAIL pinjie_on_fs: got upd=%b pj=%b expected 0 1", cfg_update, pinjie_en);
    end
    tick(6'h3F);
    checks++;
    if (mode_pending !== 1'b1) begin
      errors++; $display("FAIL pinjie_pending: got %b expected 1", mode_pending);
    end
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (pinjie_en !== 1'b0 || cfg_update !== 1'b1) begin
      errors++; $display("FAIL pinjie_commit: got pj=%b upd=%b expected 0 1", pinjie_en, cfg_update);
    end
    idle_until(VS_LEN);
    press(6'h20);
    press(6'h20);
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (cfg_update !== 1'b0 || pinjie_en !== 1'b0 || mode_pending !== 1'b0) begin
      errors++; $display("FAIL pinjie_double: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    idle_until(VS_LEN);
    press(6'h20);
    idle_until(0);
    tick(6'h3F);
    press(6'h08);
    checks++;
    if (frame_mute !== 1'b1 || mode_pending !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got mute=%b pend=%b expected 1 1", frame_mute, mode_pending);
    end
    do_reset();
    checks++;
    if (dut_vec() !== {2'd0, 1'b1, 8'd60, 3'b000}) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", dut_vec(), {2'd0, 1'b1, 8'd60, 3'b000});
    end
    idle_until(0);
    tick(6'h3F);
    checks++;
    if (cfg_update !== 1'b0 || frame_mute !== 1'b0 || sobel_thresh !== 8'd60) begin
      errors++; $display("FAIL mid_no_commit: got %h expected %h", dut_vec(), {2'd0, 1'b1, 8'd60, 3'b000});
    end
  endtask

  task automatic test_random();
    logic [5:0] k = 6'h3F;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 3) == 0) k[i] = ~k[i];
      tick(k);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_img();
    test_thresh();
    test_colour();
    test_pinjie();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
